// File: rtl/dr_pkg.sv
// Shared types, sizes and opcode constants for the decode/rename slice.
package dr_pkg;

  localparam int NUM_AREG = 32;
  localparam int NUM_PREG = 64;
  localparam int PREG_W   = $clog2(NUM_PREG);
  localparam int AREG_W   = $clog2(NUM_AREG);

  // The free list starts out holding every preg not claimed by the identity map.
  localparam int FL_DEPTH = NUM_PREG - NUM_AREG;
  localparam int FL_PTR_W = $clog2(FL_DEPTH);
  localparam int FL_CNT_W = FL_PTR_W + 1;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [AREG_W-1:0] areg_t;

  // Opcodes whose instructions write an architectural destination.
  function automatic logic writes_rd(input logic [6:0] opcode);
    return (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LW);
  endfunction

  // Sign-extended immediate for the I- and S-type formats this stage knows about.
  function automatic logic [31:0] imm_gen(input logic [31:0] instr);
    logic [31:0] imm;
    imm = '0;
    case (instr[6:0])
      OP_I, OP_LW: imm = {{20{instr[31]}}, instr[31:20]};
      OP_SW:       imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      default:     imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/dr_free_list.sv
// Circular FIFO of free physical registers. Reset contents are the pregs
// above the identity-mapped range, in ascending order starting at the head.
module dr_free_list
  import dr_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                pop,
  input  logic                push,
  input  preg_t               push_preg,
  output preg_t               head_preg,
  output logic [FL_CNT_W-1:0] count
);

  localparam logic [FL_CNT_W-1:0] FULL_CNT = FL_CNT_W'(FL_DEPTH);

  preg_t               mem [FL_DEPTH];
  logic [FL_PTR_W-1:0] head;
  logic [FL_PTR_W-1:0] tail;
  logic                push_ok;
  logic                pop_ok;

  // Pushes of p0 or into a full list are dropped; pops never underflow.
  assign push_ok   = push && (count != FULL_CNT) && (push_preg != '0);
  assign pop_ok    = pop && (count != '0);
  assign head_preg = mem[head];

  // Pointer, occupancy and storage update; pointers wrap naturally at FL_DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= FULL_CNT;
      // NOTE: this storage is reset on purpose -- the list must come up full
      // of p32..p63, so it cannot be left as uninitialised RAM.
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem[i] <= preg_t'(FL_DEPTH + i);
      end
    end else begin
      if (pop_ok) begin
        head <= head + FL_PTR_W'(1);
      end
      if (push_ok) begin
        mem[tail] <= push_preg;
        tail      <= tail + FL_PTR_W'(1);
      end
      count <= count + FL_CNT_W'(push_ok) - FL_CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/decode_rename.sv
// Decode + register-rename stage: splits the RV32 word, looks sources up in
// the RAT and allocates a destination preg from dr_free_list.
// Optional feature: define DR_IMM_EN to add the registered out_imm port.
module decode_rename
  import dr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [6:0]  out_opcode,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic [5:0]  out_ps1,
  output logic [5:0]  out_ps2,
  output logic [5:0]  out_pd,
  output logic [5:0]  out_old_pd,
  output logic        out_has_dest,
  output logic [31:0] out_instr,
  input  logic        free_valid,
  input  logic [5:0]  free_preg,
  output logic [5:0]  free_cnt
`ifdef DR_IMM_EN
  ,
  output logic [31:0] out_imm
`endif
);

  preg_t       rat [NUM_AREG];
  logic [6:0]  opcode;
  areg_t       rs1;
  areg_t       rs2;
  areg_t       rd;
  logic        needs_dest;
  logic        fire;
  logic        alloc;
  preg_t       head_preg;

  // Field split and destination decision; x0 is never given a new preg.
  assign opcode     = instr[6:0];
  assign rd         = instr[11:7];
  assign rs1        = instr[19:15];
  assign rs2        = instr[24:20];
  assign needs_dest = writes_rd(opcode) && (rd != '0);

  // Accept when the output slot frees up and a preg is on hand if one is needed.
  assign in_ready = (!out_valid || out_ready) && (!needs_dest || (free_cnt != '0));
  assign fire     = in_valid && in_ready;
  assign alloc    = fire && needs_dest;

  dr_free_list u_free_list (
    .clk       (clk),
    .rst       (rst),
    .pop       (alloc),
    .push      (free_valid),
    .push_preg (free_preg),
    .head_preg (head_preg),
    .count     (free_cnt)
  );

  // RAT: identity map at reset, rd remapped to the popped preg on allocation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_AREG; i++) begin
        rat[i] <= preg_t'(i);
      end
    end else if (alloc) begin
      // NOTE: non-blocking write, so the source lookups for this same
      // instruction below still see the old mapping (add x1,x1,x1 case).
      rat[rd] <= head_preg;
    end
  end

  // Output register: load on transfer, drop valid once dispatch takes it, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_opcode   <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_rd       <= '0;
      out_ps1      <= '0;
      out_ps2      <= '0;
      out_pd       <= '0;
      out_old_pd   <= '0;
      out_has_dest <= 1'b0;
      out_instr    <= '0;
`ifdef DR_IMM_EN
      out_imm      <= '0;
`endif
    end else if (fire) begin
      out_valid    <= 1'b1;
      out_opcode   <= opcode;
      out_rs1      <= rs1;
      out_rs2      <= rs2;
      out_rd       <= rd;
      out_ps1      <= rat[rs1];
      out_ps2      <= rat[rs2];
      out_pd       <= needs_dest ? head_preg : '0;
      out_old_pd   <= needs_dest ? rat[rd] : '0;
      out_has_dest <= needs_dest;
      out_instr    <= instr;
`ifdef DR_IMM_EN
      out_imm      <= imm_gen(instr);
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_rename.sv
// Directed bench for decode_rename; expected values are hand-derived.
module tb_decode_rename;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [5:0]  out_ps1;
  logic [5:0]  out_ps2;
  logic [5:0]  out_pd;
  logic [5:0]  out_old_pd;
  logic        out_has_dest;
  logic [31:0] out_instr;
  logic        free_valid;
  logic [5:0]  free_preg;
  logic [5:0]  free_cnt;
`ifdef DR_IMM_EN
  logic [31:0] out_imm;
`endif

  int tests_run;
  int tests_failed;

  decode_rename dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .instr        (instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_opcode   (out_opcode),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_rd       (out_rd),
    .out_ps1      (out_ps1),
    .out_ps2      (out_ps2),
    .out_pd       (out_pd),
    .out_old_pd   (out_old_pd),
    .out_has_dest (out_has_dest),
    .out_instr    (out_instr),
    .free_valid   (free_valid),
    .free_preg    (free_preg),
    .free_cnt     (free_cnt)
`ifdef DR_IMM_EN
    ,
    .out_imm      (out_imm)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    instr      = 32'h0;
    out_ready  = 1'b1;
    free_valid = 1'b0;
    free_preg  = 6'd0;
    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_free_cnt", 32'(free_cnt), 32);
    check("rst_out_pd", 32'(out_pd), 0);
    check("rst_out_instr", out_instr, 0);
    tick();
    rst = 1'b0;

    // add x3,x1,x2
    instr    = 32'h002081B3;
    in_valid = 1'b1;
    #1;
    check("add1_in_ready", 32'(in_ready), 1);
    tick();
    check("add1_valid", 32'(out_valid), 1);
    check("add1_opcode", 32'(out_opcode), 32'h33);
    check("add1_rd", 32'(out_rd), 3);
    check("add1_ps1", 32'(out_ps1), 1);
    check("add1_ps2", 32'(out_ps2), 2);
    check("add1_pd", 32'(out_pd), 32);
    check("add1_old_pd", 32'(out_old_pd), 3);
    check("add1_has_dest", 32'(out_has_dest), 1);
    check("add1_free_cnt", 32'(free_cnt), 31);

    // add x4,x3,x3
    instr = 32'h00318233;
    tick();
    check("add2_ps1", 32'(out_ps1), 32);
    check("add2_ps2", 32'(out_ps2), 32);
    check("add2_pd", 32'(out_pd), 33);
    check("add2_old_pd", 32'(out_old_pd), 4);
    check("add2_free_cnt", 32'(free_cnt), 30);

    // sw x5,0(x3)
    instr = 32'h0051A023;
    tick();
    check("sw_ps1", 32'(out_ps1), 32);
    check("sw_ps2", 32'(out_ps2), 5);
    check("sw_has_dest", 32'(out_has_dest), 0);
    check("sw_pd", 32'(out_pd), 0);
    check("sw_old_pd", 32'(out_old_pd), 0);
    check("sw_free_cnt", 32'(free_cnt), 30);

    // addi x0,x0,5
    instr = 32'h00500013;
    tick();
    check("addi_x0_has_dest", 32'(out_has_dest), 0);
    check("addi_x0_pd", 32'(out_pd), 0);
    check("addi_x0_free_cnt", 32'(free_cnt), 30);

    // add x6,x0,x4 : x0 still maps to p0, x4 to p33
    instr = 32'h00400333;
    tick();
    check("x0_ps1", 32'(out_ps1), 0);
    check("x0_ps2", 32'(out_ps2), 33);
    check("x0_pd", 32'(out_pd), 34);
    check("x0_old_pd", 32'(out_old_pd), 6);

    // add x1,x1,x1 reads the old x1 mapping
    instr = 32'h001080B3;
    tick();
    check("self_ps1", 32'(out_ps1), 1);
    check("self_ps2", 32'(out_ps2), 1);
    check("self_pd", 32'(out_pd), 35);
    check("self_old_pd", 32'(out_old_pd), 1);

    // add x7,x1,x0 sees the new x1 mapping
    instr = 32'h000083B3;
    tick();
    check("after_self_ps1", 32'(out_ps1), 35);
    check("after_self_pd", 32'(out_pd), 36);
    check("after_self_free_cnt", 32'(free_cnt), 27);

    // Fresh reset, then drain the free list with add x5,x5,x5.
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    instr    = 32'h005282B3;
    in_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      check("drain_pd", 32'(out_pd), 32'(32 + i));
      check("drain_ps1", 32'(out_ps1), (i == 0) ? 32'd5 : 32'(31 + i));
    end
    check("drain_free_cnt", 32'(free_cnt), 0);
    check("empty_in_ready", 32'(in_ready), 0);

    instr = 32'h0051A023;
    #1;
    check("empty_sw_in_ready", 32'(in_ready), 1);
    instr = 32'h005282B3;
    tick();
    check("empty_out_valid_drop", 32'(out_valid), 0);

    // p0 is never accepted back.
    in_valid   = 1'b0;
    free_valid = 1'b1;
    free_preg  = 6'd0;
    tick();
    check("push_p0_ignored", 32'(free_cnt), 0);

    // Free p3 while an alloc waits: no bypass this cycle.
    in_valid  = 1'b1;
    free_preg = 6'd3;
    #1;
    check("no_bypass_in_ready", 32'(in_ready), 0);
    tick();
    free_valid = 1'b0;
    check("free_cnt_after_push", 32'(free_cnt), 1);
    check("no_bypass_out_valid", 32'(out_valid), 0);
    tick();
    check("realloc_pd", 32'(out_pd), 3);
    check("realloc_old_pd", 32'(out_old_pd), 63);
    check("realloc_free_cnt", 32'(free_cnt), 0);

    // Backpressure: output holds, in_ready low.
    out_ready = 1'b0;
    instr     = 32'h0051A023;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready", 32'(in_ready), 0);
      tick();
      check("stall_valid", 32'(out_valid), 1);
      check("stall_pd", 32'(out_pd), 3);
      check("stall_instr", out_instr, 32'h005282B3);
    end

    // Asynchronous reset mid-stream.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_free_cnt", 32'(free_cnt), 32);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;

    // Push into a full list is dropped.
    free_valid = 1'b1;
    free_preg  = 6'd40;
    tick();
    check("push_full_ignored", 32'(free_cnt), 32);
    free_valid = 1'b0;

    // RAT identity restored after reset.
    instr    = 32'h002081B3;
    in_valid = 1'b1;
    tick();
    check("post_rst_ps1", 32'(out_ps1), 1);
    check("post_rst_ps2", 32'(out_ps2), 2);
    check("post_rst_pd", 32'(out_pd), 32);
    check("post_rst_old_pd", 32'(out_old_pd), 3);

    // Pop and push in the same cycle leave the count unchanged.
    instr      = 32'h00318233;
    free_valid = 1'b1;
    free_preg  = 6'd3;
    tick();
    free_valid = 1'b0;
    in_valid   = 1'b0;
    check("pop_push_pd", 32'(out_pd), 33);
    check("pop_push_free_cnt", 32'(free_cnt), 31);
    tick();
    check("idle_out_valid", 32'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
